disp_search_ctrl: RTL

- Sequences a wide disparity search through the combinational minimum tree, ELEM SAD values per beat.
- Accepts MAX_DISP/ELEM chunks per pixel over a valid/ready stream and tracks the running minimum cost and its disparity index.
- Emits one disparity result per pixel.
- Sits between the SAD aggregation stage and the disparity-map writer.

---
 rtl/stereo_pkg.sv | 16 +
 rtl/Min_Val.sv | 23 ++
 rtl/min_idx_enc.sv | 19 +
 rtl/disp_search_ctrl.sv | 127 ++++++++++++
 4 files changed

// File: rtl/stereo_pkg.sv
// Shared types and default sizing for the stereo disparity search path.
package stereo_pkg;

  localparam int ELEM_DEF       = 64;
  localparam int DATA_WIDTH_DEF = 8;
  localparam int MAX_DISP_DEF   = 256;

  typedef logic [DATA_WIDTH_DEF-1:0] sad_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    OUT   = 2'd2
  } disp_state_t;

endpackage

// File: rtl/Min_Val.sv
// Combinational minimum tree over ELEM packed cost values (ELEM a power of two).
module Min_Val #(
  parameter int ELEM       = 64,
  parameter int DATA_WIDTH = 8
) (
  input  logic [ELEM-1:0][DATA_WIDTH-1:0] i_data,
  output logic [DATA_WIDTH-1:0]           o_min
);

  logic [DATA_WIDTH-1:0] tree [ELEM];

  always_comb begin
    for (int i = 0; i < ELEM; i++) tree[i] = i_data[i];
    // Pairwise reduction: after the pass with stride s, tree[i] holds the min of 2s leaves.
    for (int s = 1; s < ELEM; s = s * 2) begin
      for (int i = 0; i < ELEM; i = i + 2 * s) begin
        if (tree[i+s] < tree[i]) tree[i] = tree[i+s];
      end
    end
    o_min = tree[0];
  end

endmodule

// File: rtl/min_idx_enc.sv
// Returns the lowest element index whose value equals the supplied key.
module min_idx_enc #(
  parameter int ELEM       = 64,
  parameter int DATA_WIDTH = 8
) (
  input  logic [ELEM-1:0][DATA_WIDTH-1:0] i_data,
  input  logic [DATA_WIDTH-1:0]           i_key,
  output logic [$clog2(ELEM)-1:0]         o_idx
);

  always_comb begin
    o_idx = '0;
    // Scan downward so the lowest matching index is the one left standing.
    for (int j = ELEM - 1; j >= 0; j--) begin
      if (i_data[j] == i_key) o_idx = ($clog2(ELEM))'(j);
    end
  end

endmodule

// File: rtl/disp_search_ctrl.sv
// Chunked disparity search: folds CHUNKS beats of ELEM SAD costs into one
// winning (lowest-cost, lowest-index) disparity per pixel.
module disp_search_ctrl
  import stereo_pkg::*;
#(
  parameter int ELEM       = ELEM_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int MAX_DISP   = MAX_DISP_DEF
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic                            i_soft_clr,
  input  logic                            i_sads_valid,
  output logic                            o_sads_ready,
  input  logic [ELEM-1:0][DATA_WIDTH-1:0] i_sads_data,
  output logic                            o_disp_valid,
  input  logic                            i_disp_ready,
  output logic [$clog2(MAX_DISP)-1:0]     o_disp_idx,
  output logic [DATA_WIDTH-1:0]           o_min_cost,
  output logic                            o_busy
);

  localparam int CHUNKS = MAX_DISP / ELEM;
  localparam int IDX_W  = $clog2(MAX_DISP);
  localparam int LOC_W  = $clog2(ELEM);
  localparam int CNT_W  = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CHUNKS - 1);

  disp_state_t           state, state_nxt;
  logic [CNT_W-1:0]      chunk_cnt, cnt_nxt;
  logic [DATA_WIDTH-1:0] run_min, min_nxt;
  logic [IDX_W-1:0]      run_idx, idx_nxt;

  logic [DATA_WIDTH-1:0] chunk_min;
  logic [LOC_W-1:0]      loc_idx;
  logic [IDX_W-1:0]      cand_idx;
  logic                  accept;

  Min_Val #(.ELEM(ELEM), .DATA_WIDTH(DATA_WIDTH)) u_min_val (
    .i_data (i_sads_data),
    .o_min  (chunk_min)
  );

  min_idx_enc #(.ELEM(ELEM), .DATA_WIDTH(DATA_WIDTH)) u_min_idx_enc (
    .i_data (i_sads_data),
    .i_key  (chunk_min),
    .o_idx  (loc_idx)
  );

  // ELEM is a power of two, so chunk base + local offset is a pure concatenation.
  if (CHUNKS > 1) begin : g_cat
    assign cand_idx = {chunk_cnt, loc_idx};
  end else begin : g_one
    assign cand_idx = loc_idx;
  end

  assign o_sads_ready = i_rst_n && (state != OUT);
  assign o_disp_valid = (state == OUT);
  assign o_busy       = (state != IDLE);
  assign o_disp_idx   = run_idx;
  assign o_min_cost   = run_min;
  assign accept       = i_sads_valid && o_sads_ready;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = chunk_cnt;
    min_nxt   = run_min;
    idx_nxt   = run_idx;
    case (state)
      IDLE: begin
        if (accept) begin
          min_nxt = chunk_min;
          idx_nxt = cand_idx;
          if (CHUNKS == 1) begin
            state_nxt = OUT;
          end else begin
            cnt_nxt   = CNT_W'(1);
            state_nxt = ACCUM;
          end
        end
      end
      ACCUM: begin
        if (accept) begin
          // Strict compare: an equal cost in a later chunk never displaces a lower disparity.
          if (chunk_min < run_min) begin
            min_nxt = chunk_min;
            idx_nxt = cand_idx;
          end
          if (chunk_cnt == LAST_CNT) begin
            cnt_nxt   = '0;
            state_nxt = OUT;
          end else begin
            cnt_nxt = chunk_cnt + CNT_W'(1);
          end
        end
      end
      OUT: begin
        if (i_disp_ready) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
    if (i_soft_clr) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
      min_nxt   = run_min;
      idx_nxt   = run_idx;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= IDLE;
      chunk_cnt <= '0;
      run_min   <= '0;
      run_idx   <= '0;
    end else begin
      state     <= state_nxt;
      chunk_cnt <= cnt_nxt;
      run_min   <= min_nxt;
      run_idx   <= idx_nxt;
    end
  end

endmodule
